// File: rtl/alu_pkg.sv
// Shared definitions for the ALU time-sharing arbiter: ALU control codes,
// FSM state encoding and requester count.
package alu_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_RSV0 = 3'b011,
        ALU_SUB  = 3'b100,
        ALU_MUL  = 3'b101,
        ALU_SLT  = 3'b110,
        ALU_RSV1 = 3'b111
    } alu_ctrl_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    function automatic logic is_reserved_ctrl(input logic [2:0] ctrl);
        return (ctrl == ALU_RSV0) || (ctrl == ALU_RSV1);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bus between the two ALU requesters and the arbiter.
// The master side is the requesters, the slave side is the arbiter.
interface alu_share_arbiter_if
    import alu_pkg::*;
#(
    parameter int DATA_SIZE = 32
) ();

    logic [NUM_REQ-1:0]           req_valid_i;
    logic [NUM_REQ-1:0]           req_ready_o;
    logic [NUM_REQ*DATA_SIZE-1:0] req_a_i;
    logic [NUM_REQ*DATA_SIZE-1:0] req_b_i;
    logic [NUM_REQ*3-1:0]         req_ctrl_i;
    logic [NUM_REQ-1:0]           resp_valid_o;
    logic [NUM_REQ-1:0]           resp_ready_i;
    logic [DATA_SIZE-1:0]         resp_result_o;
    logic                         resp_zero_o;
    logic                         resp_err_o;

    modport master (
        output req_valid_i, req_a_i, req_b_i, req_ctrl_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_result_o, resp_zero_o, resp_err_o
    );

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, req_ctrl_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_result_o, resp_zero_o, resp_err_o
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: a lone request always wins, a tie goes to
// the requester selected by rr_ptr_i.
module rr_arb2
    import alu_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic               rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               grant_id_o
);

    always_comb begin
        grant_o    = 2'b00;
        grant_id_o = 1'b0;
        case (valid_i)
            2'b01: begin
                grant_o    = 2'b01;
                grant_id_o = 1'b0;
            end
            2'b10: begin
                grant_o    = 2'b10;
                grant_id_o = 1'b1;
            end
            2'b11: begin
                grant_o    = rr_ptr_i ? 2'b10 : 2'b01;
                grant_id_o = rr_ptr_i;
            end
            default: begin
                grant_o    = 2'b00;
                grant_id_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external combinational MIPS ALU between two requesters:
// accept one op, drive the ALU for a cycle, hold the registered result until taken.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus,
    output logic [DATA_SIZE-1:0] alu_srca_o,
    output logic [DATA_SIZE-1:0] alu_srcb_o,
    output logic [2:0]           alu_ctrl_o,
    input  logic [DATA_SIZE-1:0] alu_result_i,
    input  logic                 alu_zero_i,
    output logic                 busy_o
);

    state_t               state_q, state_d;
    logic                 rr_ptr_q, rr_ptr_d;
    logic                 grant_id_q, grant_id_d;
    logic [DATA_SIZE-1:0] srca_q, srca_d;
    logic [DATA_SIZE-1:0] srcb_q, srcb_d;
    logic [2:0]           ctrl_q, ctrl_d;
    logic [DATA_SIZE-1:0] result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 err_q, err_d;

    logic [NUM_REQ-1:0]   grant;
    logic                 grant_id;

    rr_arb2 u_rr_arb2 (
        .valid_i    (bus.req_valid_i),
        .rr_ptr_i   (rr_ptr_q),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        srca_d     = srca_q;
        srcb_d     = srcb_q;
        ctrl_d     = ctrl_q;
        result_d   = result_q;
        zero_d     = zero_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    grant_id_d = grant_id;
                    srca_d     = grant_id ? bus.req_a_i[DATA_SIZE +: DATA_SIZE]
                                          : bus.req_a_i[0 +: DATA_SIZE];
                    srcb_d     = grant_id ? bus.req_b_i[DATA_SIZE +: DATA_SIZE]
                                          : bus.req_b_i[0 +: DATA_SIZE];
                    ctrl_d     = grant_id ? bus.req_ctrl_i[5:3] : bus.req_ctrl_i[2:0];
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = alu_result_i;
                zero_d   = alu_zero_i;
                err_d    = is_reserved_ctrl(ctrl_q);
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                // Only the owner of the pending result can retire it.
                if (bus.resp_ready_i[grant_id_q]) begin
                    rr_ptr_d = ~grant_id_q;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= 1'b0;
            grant_id_q <= 1'b0;
            srca_q     <= '0;
            srcb_q     <= '0;
            ctrl_q     <= 3'b000;
            result_q   <= '0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            srca_q     <= srca_d;
            srcb_q     <= srcb_d;
            ctrl_q     <= ctrl_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            err_q      <= err_d;
        end
    end

    // Ready is suppressed while reset is asserted so nothing looks accepted.
    assign bus.req_ready_o   = ((state_q == ST_IDLE) && rst_n) ? grant : 2'b00;
    assign bus.resp_valid_o  = (state_q == ST_RESP) ? (grant_id_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.resp_result_o = result_q;
    assign bus.resp_zero_o   = zero_q;
    assign bus.resp_err_o    = err_q;

    assign alu_srca_o = srca_q;
    assign alu_srcb_o = srcb_q;
    assign alu_ctrl_o = ctrl_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter: a behavioural ALU sits on the alu_* ports
// and a transaction-level model predicts grant order, latency and results.
module tb_alu_share_arbiter;

    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] alu_srca;
    logic [DW-1:0] alu_srcb;
    logic [2:0]    alu_ctrl;
    logic [DW-1:0] alu_result;
    logic          alu_zero;
    logic          busy;

    int   checks = 0;
    int   errors = 0;
    logic prefer = 1'b0;

    alu_share_arbiter_if #(.DATA_SIZE(DW)) bus ();

    alu_share_arbiter #(.DATA_SIZE(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_srca_o   (alu_srca),
        .alu_srcb_o   (alu_srcb),
        .alu_ctrl_o   (alu_ctrl),
        .alu_result_i (alu_result),
        .alu_zero_i   (alu_zero),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [2:0] c);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b100:  return a - b;
            3'b101:  return a * b;
            3'b110:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    function automatic logic rsv(input logic [2:0] c);
        return c[1:0] == 2'b11;
    endfunction

    // Behavioural MIPS ALU hanging off the alu_* ports.
    always_comb begin
        alu_result = alu_ref(alu_srca, alu_srcb, alu_ctrl);
        alu_zero   = (alu_result == '0);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_inputs();
        bus.req_valid_i  = 2'b00;
        bus.req_a_i      = '0;
        bus.req_b_i      = '0;
        bus.req_ctrl_i   = '0;
        bus.resp_ready_i = 2'b00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk); #1;
        rst_n  = 1'b1;
        prefer = 1'b0;
    endtask

    // Drives one operation and retires its response; entered and left just after a rising edge.
    task automatic serve_one(input logic [1:0] v, input logic [63:0] a, input logic [63:0] b,
                             input logic [5:0] c, input int delay, output logic [1:0] g,
                             output int lat, output logic [DW-1:0] res, output logic z,
                             output logic e, output logic [1:0] rv, output bit tmo);
        g = 2'b00; lat = 0; res = '0; z = 1'b0; e = 1'b0; rv = 2'b00; tmo = 1'b0;
        bus.req_valid_i = v;
        bus.req_a_i     = a;
        bus.req_b_i     = b;
        bus.req_ctrl_i  = c;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.req_ready_o != 2'b00) begin
                g = bus.req_ready_o;
                break;
            end
            @(posedge clk); #1;
        end
        if (g == 2'b00) begin
            tmo = 1'b1;
            bus.req_valid_i = 2'b00;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid_i = bus.req_valid_i & ~g;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.resp_valid_o != 2'b00) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            tmo = 1'b1;
            return;
        end
        rv  = bus.resp_valid_o;
        res = bus.resp_result_o;
        z   = bus.resp_zero_o;
        e   = bus.resp_err_o;
        repeat (delay) @(negedge clk);
        bus.resp_ready_i = rv;
        @(posedge clk); #1;
        bus.resp_ready_i = 2'b00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        bus.req_valid_i = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (bus.req_ready_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 00", bus.req_ready_o); end
        checks++;
        if (bus.resp_valid_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b expected 00", bus.resp_valid_o); end
        checks++;
        if ({bus.resp_result_o, bus.resp_zero_o, bus.resp_err_o} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_resp: got result=%h zero=%b err=%b expected all 0", bus.resp_result_o, bus.resp_zero_o, bus.resp_err_o);
        end
        checks++;
        if ({alu_srca, alu_srcb, alu_ctrl} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_alu: got srca=%h srcb=%h ctrl=%b expected all 0", alu_srca, alu_srcb, alu_ctrl);
        end
        bus.req_valid_i = 2'b00;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        prefer = 1'b0;
    endtask

    task automatic test_single();
        bus.req_valid_i = 2'b01;
        bus.req_a_i     = {32'hdead_beef, 32'd5};
        bus.req_b_i     = {32'h1234_5678, 32'd7};
        bus.req_ctrl_i  = {3'b001, 3'b010};
        @(negedge clk);
        checks++;
        if (bus.req_ready_o !== 2'b01) begin errors++; $display("[TB] FAIL single_ready: got %b expected 01", bus.req_ready_o); end
        @(posedge clk); #1;
        bus.req_valid_i = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.resp_valid_o !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_exec: got resp_valid=%b busy=%b expected 00 1", bus.resp_valid_o, busy);
        end
        checks++;
        if (alu_srca !== 32'd5 || alu_srcb !== 32'd7 || alu_ctrl !== 3'b010) begin
            errors++;
            $display("[TB] FAIL single_alu_drive: got %0d %0d %b expected 5 7 010", alu_srca, alu_srcb, alu_ctrl);
        end
        @(negedge clk);
        checks++;
        if (bus.resp_valid_o !== 2'b01) begin errors++; $display("[TB] FAIL single_resp_valid: got %b expected 01", bus.resp_valid_o); end
        checks++;
        if (bus.resp_result_o !== 32'd12 || bus.resp_zero_o !== 1'b0 || bus.resp_err_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_result: got %0d z=%b e=%b expected 12 0 0", bus.resp_result_o, bus.resp_zero_o, bus.resp_err_o);
        end
        bus.resp_ready_i = 2'b01;
        @(posedge clk); #1;
        bus.resp_ready_i = 2'b00;
        prefer = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: got busy=%b expected 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_alternation();
        logic [DW-1:0] ra [2];
        logic [DW-1:0] rb [2];
        logic [2:0]    rc [2];
        logic [1:0]    g, rv;
        logic [DW-1:0] res, exp_res;
        logic          z, e, id;
        int            lat;
        bit            tmo;
        do_reset();
        ra[0] = 32'd9; rb[0] = 32'd9; rc[0] = 3'b100;
        ra[1] = 32'd4; rb[1] = 32'd1; rc[1] = 3'b001;
        for (int k = 0; k < 6; k++) begin
            id      = prefer;
            exp_res = alu_ref(ra[id], rb[id], rc[id]);
            serve_one(2'b11, {ra[1], ra[0]}, {rb[1], rb[0]}, {rc[1], rc[0]}, 0, g, lat, res, z, e, rv, tmo);
            checks++;
            if (tmo) begin errors++; $display("[TB] FAIL alt_timeout: op %0d got no handshake expected one", k); end
            checks++;
            if (g !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("[TB] FAIL alt_grant: op %0d got %b expected %b", k, g, (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            checks++;
            if (res !== exp_res || z !== (exp_res == '0) || e !== rsv(rc[id]) || rv !== g || lat !== 2) begin
                errors++;
                $display("[TB] FAIL alt_result: op %0d got res=%h z=%b e=%b rv=%b lat=%0d expected res=%h z=%b e=%b rv=%b lat=2",
                         k, res, z, e, rv, lat, exp_res, exp_res == '0, rsv(rc[id]), g);
            end
            prefer = ~id;
            ra[id] = $urandom;
            rb[id] = $urandom;
            rc[id] = 3'($urandom_range(7, 0));
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] a0, b0, a1, b1, exp0, exp1;
        bit            held_ok;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        exp0 = alu_ref(a0, b0, 3'b010);
        exp1 = alu_ref(a1, b1, 3'b100);
        bus.req_valid_i = 2'b01;
        bus.req_a_i     = {a1, a0};
        bus.req_b_i     = {b1, b0};
        bus.req_ctrl_i  = {3'b100, 3'b010};
        @(negedge clk);
        checks++;
        if (bus.req_ready_o !== 2'b01) begin errors++; $display("[TB] FAIL bp_accept: got %b expected 01", bus.req_ready_o); end
        @(posedge clk); #1;
        bus.req_valid_i = 2'b10;
        @(negedge clk);
        checks++;
        if (bus.req_ready_o !== 2'b00) begin errors++; $display("[TB] FAIL bp_exec_ready: got %b expected 00", bus.req_ready_o); end
        @(negedge clk);
        checks++;
        if (bus.resp_valid_o !== 2'b01 || bus.resp_result_o !== exp0) begin
            errors++;
            $display("[TB] FAIL bp_resp: got valid=%b res=%h expected 01 %h", bus.resp_valid_o, bus.resp_result_o, exp0);
        end
        held_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.resp_valid_o !== 2'b01 || bus.resp_result_o !== exp0 || bus.req_ready_o !== 2'b00 || busy !== 1'b1)
                held_ok = 1'b0;
        end
        checks++;
        if (!held_ok) begin
            errors++;
            $display("[TB] FAIL bp_hold: got valid=%b res=%h ready=%b expected 01 %h 00", bus.resp_valid_o, bus.resp_result_o, bus.req_ready_o, exp0);
        end
        bus.resp_ready_i = 2'b01;
        @(posedge clk); #1;
        bus.resp_ready_i = 2'b00;
        prefer = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready_o !== 2'b10) begin errors++; $display("[TB] FAIL bp_r1_accept: got %b expected 10", bus.req_ready_o); end
        @(posedge clk); #1;
        bus.req_valid_i = 2'b00;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.resp_valid_o !== 2'b10 || bus.resp_result_o !== exp1 || bus.resp_zero_o !== (exp1 == '0)) begin
            errors++;
            $display("[TB] FAIL bp_r1_resp: got valid=%b res=%h z=%b expected 10 %h %b", bus.resp_valid_o, bus.resp_result_o, bus.resp_zero_o, exp1, exp1 == '0);
        end
        bus.resp_ready_i = 2'b10;
        @(posedge clk); #1;
        bus.resp_ready_i = 2'b00;
        prefer = 1'b0;
    endtask

    task automatic test_reserved();
        logic [1:0]    g, rv;
        logic [DW-1:0] res, a0, b0;
        logic          z, e;
        int            lat;
        bit            tmo;
        a0 = $urandom; b0 = $urandom;
        serve_one(2'b10, {32'd77, a0}, {32'd3, b0}, {3'b111, 3'b000}, 1, g, lat, res, z, e, rv, tmo);
        checks++;
        if (tmo || g !== 2'b10 || res !== '0 || z !== 1'b1 || e !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rsv_err: got tmo=%b g=%b res=%h z=%b e=%b expected 0 10 0 1 1", tmo, g, res, z, e);
        end
        prefer = 1'b0;
        serve_one(2'b01, {32'd77, a0}, {32'd3, b0}, {3'b111, 3'b000}, 0, g, lat, res, z, e, rv, tmo);
        checks++;
        if (tmo || g !== 2'b01 || res !== (a0 & b0) || e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rsv_clear: got tmo=%b g=%b res=%h e=%b expected 0 01 %h 0", tmo, g, res, e, a0 & b0);
        end
        prefer = 1'b1;
    endtask

    task automatic test_wrong_ready();
        bus.req_valid_i = 2'b01;
        bus.req_a_i     = {32'd1, 32'd20};
        bus.req_b_i     = {32'd1, 32'd30};
        bus.req_ctrl_i  = {3'b010, 3'b110};
        @(negedge clk);
        @(posedge clk); #1;
        bus.req_valid_i = 2'b00;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.resp_valid_o !== 2'b01 || bus.resp_result_o !== 32'd1) begin
            errors++;
            $display("[TB] FAIL wr_resp: got valid=%b res=%h expected 01 1", bus.resp_valid_o, bus.resp_result_o);
        end
        bus.resp_ready_i = 2'b10;
        @(posedge clk); #1;
        bus.resp_ready_i = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.resp_valid_o !== 2'b01 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wr_ignored: got valid=%b busy=%b expected 01 1", bus.resp_valid_o, busy);
        end
        bus.resp_ready_i = 2'b01;
        @(posedge clk); #1;
        bus.resp_ready_i = 2'b00;
        prefer = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.resp_valid_o !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wr_release: got valid=%b busy=%b expected 00 0", bus.resp_valid_o, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_exec();
        logic [1:0]    g, rv, exp_g;
        logic [DW-1:0] res;
        logic          z, e;
        int            lat;
        bit            tmo, quiet;
        exp_g = prefer ? 2'b10 : 2'b01;
        bus.req_valid_i = 2'b11;
        bus.req_a_i     = {32'd6, 32'd8};
        bus.req_b_i     = {32'd2, 32'd3};
        bus.req_ctrl_i  = {3'b101, 3'b010};
        @(negedge clk);
        checks++;
        if (bus.req_ready_o !== exp_g) begin errors++; $display("[TB] FAIL rx_grant: got %b expected %b", bus.req_ready_o, exp_g); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.req_valid_i = 2'b00;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        prefer = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.resp_valid_o !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rx_state: got busy=%b valid=%b expected 0 00", busy, bus.resp_valid_o);
        end
        checks++;
        if ({bus.resp_result_o, bus.resp_zero_o, bus.resp_err_o, alu_srca, alu_srcb, alu_ctrl} !== '0) begin
            errors++;
            $display("[TB] FAIL rx_outputs: got res=%h z=%b e=%b srca=%h srcb=%h ctrl=%b expected all 0",
                     bus.resp_result_o, bus.resp_zero_o, bus.resp_err_o, alu_srca, alu_srcb, alu_ctrl);
        end
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid_o !== 2'b00) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin errors++; $display("[TB] FAIL rx_no_resp: got a response after reset expected none"); end
        @(posedge clk); #1;
        serve_one(2'b11, {32'd6, 32'd8}, {32'd2, 32'd3}, {3'b101, 3'b010}, 0, g, lat, res, z, e, rv, tmo);
        checks++;
        if (tmo || g !== 2'b01 || res !== 32'd11) begin
            errors++;
            $display("[TB] FAIL rx_after: got tmo=%b g=%b res=%0d expected 0 01 11", tmo, g, res);
        end
        prefer = 1'b1;
    endtask

    task automatic test_random();
        logic [1:0]    v, g, rv, exp_g;
        logic [63:0]   a, b;
        logic [5:0]    c;
        logic [DW-1:0] res, exp_res;
        logic          z, e, id;
        int            lat;
        bit            tmo;
        for (int k = 0; k < 20; k++) begin
            v = 2'($urandom_range(3, 1));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(3, 0) == 0) b = a;
            c = 6'($urandom_range(63, 0));
            exp_g   = (v == 2'b11) ? (prefer ? 2'b10 : 2'b01) : v;
            id      = (exp_g == 2'b10);
            exp_res = alu_ref(a[id*DW +: DW], b[id*DW +: DW], c[id*3 +: 3]);
            serve_one(v, a, b, c, $urandom_range(2, 0), g, lat, res, z, e, rv, tmo);
            checks++;
            if (tmo || g !== exp_g || rv !== exp_g || lat !== 2) begin
                errors++;
                $display("[TB] FAIL rnd_handshake: op %0d got tmo=%b g=%b rv=%b lat=%0d expected 0 %b %b 2", k, tmo, g, rv, lat, exp_g, exp_g);
            end
            checks++;
            if (res !== exp_res || z !== (exp_res == '0) || e !== rsv(c[id*3 +: 3])) begin
                errors++;
                $display("[TB] FAIL rnd_result: op %0d got res=%h z=%b e=%b expected %h %b %b",
                         k, res, z, e, exp_res, exp_res == '0, rsv(c[id*3 +: 3]));
            end
            prefer = ~id;
        end
    endtask

    initial begin
        $display("[TB] starting alu_share_arbiter bench");
        test_reset();
        test_single();
        test_alternation();
        test_backpressure();
        test_reserved();
        test_wrong_ready();
        test_reset_exec();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Two-requester scheduler that time-shares the single combinational MIPS ALU (SrcA/SrcB/ALUControl in, ALUResult/Zero out). Requester 0 is the main datapath and requester 1 is the auxiliary unit (branch-target/debug). The block accepts one operation at a time, arbitrates round-robin, registers operands, drives the ALU for one cycle, registers the result and returns it with a valid/ready handshake. The ALU itself stays outside the block and is connected through the alu_* ports.

Parameters:
DATA_SIZE, 32, operand/result width; must match the ALU instance.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
req_valid_i  input  2  per-requester operation request, bit k = requester k
req_ready_o  output  2  per-requester accept, one-hot or zero
req_a_i  input  2*DATA_SIZE  operand A; requester k at bits [k*DATA_SIZE +: DATA_SIZE]
req_b_i  input  2*DATA_SIZE  operand B, same packing
req_ctrl_i  input  6  3-bit ALU control per requester, requester k at [k*3 +: 3]
resp_valid_o  output  2  result valid, one-hot or zero
resp_ready_i  input  2  requester accepts result
resp_result_o  output  DATA_SIZE  registered ALU result, shared by both requesters
resp_zero_o  output  1  registered Zero flag
resp_err_o  output  1  set when the captured ctrl was 3'b011 or 3'b111 (reserved codes)
alu_srca_o  output  DATA_SIZE  to ALU SrcA
alu_srcb_o  output  DATA_SIZE  to ALU SrcB
alu_ctrl_o  output  3  to ALU ALUControl
alu_result_i  input  DATA_SIZE  from ALU ALUResult
alu_zero_i  input  1  from ALU Zero
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE.
  - All captured registers, resp_result_o, resp_zero_o and resp_err_o are cleared to 0.
  - alu_srca_o, alu_srcb_o and alu_ctrl_o go to 0.
  - rr_ptr goes to 0.
  - req_ready_o and resp_valid_o are 0.
  - Reset overrides everything. An operation in flight is discarded and no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is computed combinationally. With one request valid, that requester wins. With both valid, requester rr_ptr wins.
  - req_ready_o = one-hot grant, and is 0 when no request is valid.
  - On the accept edge, capture a, b and ctrl of the winner plus grant_id, then go to EXEC.
  - req_ready_o never depends on req_ready_o itself. The grant is stable only within that cycle; a requester may drop valid without penalty before it is accepted.
- EXEC (exactly 1 cycle):
  - alu_* outputs carry the captured operands; they are driven from registers in all states.
  - At the end of the cycle, register alu_result_i into resp_result_o and alu_zero_i into resp_zero_o.
  - resp_err_o = (ctrl == 3'b011 or ctrl == 3'b111).
  - Go to RESP.
- RESP:
  - resp_valid_o[grant_id] = 1. resp_result_o, resp_zero_o and resp_err_o are held stable.
  - Stays in RESP until resp_ready_i[grant_id] is 1. resp_ready_i of the non-granted requester is ignored.
  - On that handshake: rr_ptr becomes ~grant_id, then go to IDLE.
- Latency and throughput: accept at cycle N gives resp_valid at N+2. With the response accepted at once, the minimum period is 3 cycles per operation.
- req_ready_o is 0 in EXEC and RESP. New requests wait, and valid must be held by the requester.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- Starvation bound: a waiting requester is served within one foreign operation.
- Arithmetic lives entirely in the ALU; this block performs no width changes.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU control encodings: AND=000, OR=001, ADD=010, RSV0=011, SUB=100, MUL=101, SLT=110, RSV1=111;
  - the FSM state typedef (IDLE/EXEC/RESP);
  - NUM_REQ=2.
- One natural sub-module: rr_arb2, the two-input round-robin grant logic (combinational, given rr_ptr and valids).

Test Plan:
- Single request, requester 0, ADD with a=5, b=7 -> req_ready_o=01 at N; resp_valid_o=01 at N+2 with result=12, zero=0, err=0.
- Both requesters valid from reset: r0 SUB 9-9, r1 OR 4|1 -> r0 is served first with result 0 and zero=1; then r1 is granted in the next IDLE with result 5; grants alternate over 6 ops: 0,1,0,1,0,1.
- Response backpressure: resp_ready_i held low for 4 cycles -> resp_valid and the result stay stable, req_ready_o=00 throughout, and the held r1 request is accepted only after the handshake.
- Reserved control code: r1 ctrl=3'b111 -> result 0, zero=1, err=1; the next op with ctrl=000 shows err=0.
- rst_n asserted low during EXEC -> next cycle: IDLE, busy_o=0, resp_valid_o=00, all outputs 0, rr_ptr=0; a subsequent dual request grants r0.
- Wrong-side ready: in RESP for r0, pulse resp_ready_i=10 -> no state change; then resp_ready_i=01 -> return to IDLE.
